// File: rtl/or_nway_reduce_pipe_pkg.sv
// Shared definitions for the pipelined N-way OR reducer.
// Holds the frame mode encodings and the elaboration-time helpers that size
// the OR tree: how many register stages it needs, how wide each stage's
// output is, and where each stage's output lives on the flat inter-stage bus.
package or_nway_reduce_pipe_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_STICKY = 1'b1;

  // Smallest n >= 1 with fanin**n >= width, i.e. max(1, ceil(log_fanin(width))).
  function automatic int calc_stages(input int width, input int fanin);
    int n;
    longint cap;
    n   = 0;
    cap = 1;
    for (int i = 0; i < 32; i++) begin
      if (cap < longint'(width)) begin
        cap = cap * longint'(fanin);
        n++;
      end
    end
    if (n < 1) n = 1;
    return n;
  endfunction

  // Number of bits entering stage k (k = 0 is the raw frame); each stage
  // divides the width by fanin, rounding up for the zero-padded last group.
  function automatic int stage_width(input int width, input int fanin, input int k);
    int w;
    w = width;
    for (int i = 0; i < k; i++) begin
      w = (w + fanin - 1) / fanin;
    end
    return w;
  endfunction

  // Bit offset of stage k's output on the flat bus that links the stages.
  function automatic int bus_offset(input int width, input int fanin, input int k);
    int off;
    off = 0;
    for (int i = 0; i < k; i++) begin
      off = off + stage_width(width, fanin, i + 1);
    end
    return off;
  endfunction

endpackage

// File: rtl/or_tree_stage.sv
// One registered level of the OR tree.
// Splits in_data into groups of FANIN bits (the last group zero-padded),
// ORs each group and registers the results together with the frame's valid
// bit and captured mode whenever en is high.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   en              load the register (pipeline advance)
//   in_valid/in_mode/in_data     frame entering this level
//   out_valid/out_mode/out_data  registered frame leaving this level
module or_tree_stage #(
  parameter int IN_W  = 8,
  parameter int FANIN = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 in_valid,
  input  logic                                 in_mode,
  input  logic [IN_W-1:0]                      in_data,
  output logic                                 out_valid,
  output logic                                 out_mode,
  output logic [(IN_W + FANIN - 1) / FANIN-1:0] out_data
);

  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;
  localparam int PAD_W = OUT_W * FANIN;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] groupOr;

  // Zero-extend the input to a whole number of groups so every node sees
  // exactly FANIN inputs; the padding bits cannot change an OR result.
  always_comb begin
    padded  = PAD_W'(in_data);
    groupOr = '0;
    for (int g = 0; g < OUT_W; g++) begin
      groupOr[g] = |padded[g*FANIN +: FANIN];
    end
  end

  // Level register; holds its contents while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_data  <= groupOr;
    end
  end

endmodule

// File: rtl/or_nway_reduce_pipe.sv
// Pipelined WIDTH-bit to 1-bit OR reducer with valid/ready flow control.
// A chain of STAGES or_tree_stage levels reduces each frame to one bit; the
// last level is the head frame presented to the consumer. A sticky flag
// accumulates results of mode-1 frames and a saturating counter tallies
// output transfers whose frame OR was 1. clear zeroes both without touching
// the frames in flight.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          producer handshake; in_data, in_mode = frame and mode
//   clear                      zero the sticky flag and hit counter
//   out_valid/out_ready        consumer handshake; out_or = head frame result
//   out_sticky                 sticky accumulator
//   hit_count                  saturating count of transfers with a 1 result
module or_nway_reduce_pipe
  import or_nway_reduce_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int FANIN   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_mode,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_or,
  output logic               out_sticky,
  output logic [COUNT_W-1:0] hit_count
);

  localparam int STAGES  = calc_stages(WIDTH, FANIN);
  localparam int TOTAL_W = bus_offset(WIDTH, FANIN, STAGES);

  logic [TOTAL_W-1:0] dataBus;
  logic [STAGES-1:0]  validBus;
  logic [STAGES-1:0]  modeBus;

  logic               advance;
  logic               outXfer;
  logic               frameOr;
  logic               headMode;
  logic               stickyReg;
  logic [COUNT_W-1:0] hitCount;

  // The whole pipe moves together whenever the head slot is empty or being
  // taken, so bubbles get squeezed out only by shifting them forward.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Build the tree: each level's output slice on dataBus feeds the next level.
  for (genvar k = 0; k < STAGES; k++) begin : stageGen
    localparam int IN_W    = stage_width(WIDTH, FANIN, k);
    localparam int OUT_W   = stage_width(WIDTH, FANIN, k + 1);
    localparam int OUT_OFF = bus_offset(WIDTH, FANIN, k);

    logic [IN_W-1:0] stageIn;
    logic            stageInValid;
    logic            stageInMode;

    if (k == 0) begin : firstGen
      assign stageIn      = in_data;
      assign stageInValid = in_valid;
      assign stageInMode  = in_mode;
    end else begin : chainGen
      localparam int IN_OFF = bus_offset(WIDTH, FANIN, k - 1);
      assign stageIn      = dataBus[IN_OFF +: IN_W];
      assign stageInValid = validBus[k-1];
      assign stageInMode  = modeBus[k-1];
    end

    or_tree_stage #(
      .IN_W  (IN_W),
      .FANIN (FANIN)
    ) stageInst (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_valid  (stageInValid),
      .in_mode   (stageInMode),
      .in_data   (stageIn),
      .out_valid (validBus[k]),
      .out_mode  (modeBus[k]),
      .out_data  (dataBus[OUT_OFF +: OUT_W])
    );
  end

  // The last level is one bit wide, so its single bit is the head frame's OR.
  assign frameOr   = dataBus[TOTAL_W-1];
  assign headMode  = modeBus[STAGES-1];
  assign out_valid = validBus[STAGES-1];
  assign outXfer   = out_valid && out_ready;

  // Sticky frames see the accumulator as it was before this frame lands;
  // the result is forced low while no frame is presented.
  assign out_or     = out_valid && (frameOr || (headMode == MODE_STICKY && stickyReg));
  assign out_sticky = stickyReg;
  assign hit_count  = hitCount;

  // Accumulator and hit counter. clear wins over a same-cycle transfer so the
  // transferring frame is dropped from both.
  always_ff @(posedge clk) begin
    if (reset) begin
      stickyReg <= 1'b0;
      hitCount  <= '0;
    end else if (clear) begin
      stickyReg <= 1'b0;
      hitCount  <= '0;
    end else if (outXfer) begin
      if (headMode == MODE_STICKY) begin
        stickyReg <= stickyReg || frameOr;
      end
      if (frameOr && hitCount != '1) begin
        hitCount <= hitCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_or_nway_reduce_pipe.sv
// Self-checking bench for or_nway_reduce_pipe: a vector table for the main
// streaming behaviour, hand-written sequences for stall, clear and reset
// corners, extra builds for COUNT_W=2, WIDTH=1 and WIDTH=13, and a
// randomized run against a slot-level reference model.
module tb_or_nway_reduce_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        inValid;
  logic [7:0]  inData;
  logic        inData1;
  logic [12:0] inData13;
  logic        inMode;
  logic        clear;
  logic        outReady;

  logic       inReady,  outValid,  outOr,  outSticky;
  logic [7:0] hitCount;
  logic       inReadyC, outValidC, outOrC, outStickyC;
  logic [1:0] hitCountC;
  logic       inReady1, outValid1, outOr1, outSticky1;
  logic [7:0] hitCount1;
  logic       inReady13, outValid13, outOr13, outSticky13;
  logic [7:0] hitCount13;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic [7:0] data;
    logic       mode;
    logic       expOr;
    logic       expSticky;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  or_nway_reduce_pipe dut (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_data(inData), .in_mode(inMode), .clear(clear), .out_valid(outValid),
    .out_ready(outReady), .out_or(outOr), .out_sticky(outSticky), .hit_count(hitCount)
  );

  or_nway_reduce_pipe #(.COUNT_W(2)) dutCnt (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReadyC),
    .in_data(inData), .in_mode(inMode), .clear(clear), .out_valid(outValidC),
    .out_ready(outReady), .out_or(outOrC), .out_sticky(outStickyC), .hit_count(hitCountC)
  );

  or_nway_reduce_pipe #(.WIDTH(1)) dutW1 (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady1),
    .in_data(inData1), .in_mode(inMode), .clear(clear), .out_valid(outValid1),
    .out_ready(outReady), .out_or(outOr1), .out_sticky(outSticky1), .hit_count(hitCount1)
  );

  or_nway_reduce_pipe #(.WIDTH(13)) dutW13 (
    .clk(clock), .reset(reset), .in_valid(inValid), .in_ready(inReady13),
    .in_data(inData13), .in_mode(inMode), .clear(clear), .out_valid(outValid13),
    .out_ready(outReady), .out_or(outOr13), .out_sticky(outSticky13), .hit_count(hitCount13)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic mode);
    inValid = valid;
    inData  = data;
    inMode  = mode;
  endtask

  // Two reset edges, then release at a falling edge.
  task automatic doReset();
    reset    = 1'b1;
    clear    = 1'b0;
    outReady = 1'b1;
    inData1  = 1'b0;
    inData13 = '0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  // Reference model: two pipeline slots that shift on advance, plus the
  // sticky flag and hit counter, all derived from the behavioural rules.
  logic       mValid[2];
  logic [7:0] mData[2];
  logic       mMode[2];
  logic       mSticky;
  int         mCount;

  initial begin
    vecs[0] = '{8'h02, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h10, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h00, 1'b1, 1'b1, 1'b1};

    doReset();
    checkOutput("reset out_valid", outValid, 0);
    checkOutput("reset out_or", outOr, 0);
    checkOutput("reset out_sticky", outSticky, 0);
    checkOutput("reset hit_count", hitCount, 0);
    checkOutput("reset in_ready", inReady, 1);

    // Streamed vector table: frame i is presented two cycles after it is sent.
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      if (i < 9) applyStimulus(1'b1, vecs[i].data, vecs[i].mode);
      else       applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput($sformatf("vec in_ready c%0d", i), inReady, 1);
      if (i >= 2) begin
        checkOutput($sformatf("vec%0d out_valid", i - 2), outValid, 1);
        checkOutput($sformatf("vec%0d out_or", i - 2), outOr, vecs[i-2].expOr);
        checkOutput($sformatf("vec%0d out_sticky", i - 2), outSticky, vecs[i-2].expSticky);
      end else begin
        checkOutput($sformatf("latency out_valid c%0d", i), outValid, 0);
      end
    end
    @(negedge clock); #1;
    checkOutput("table drained out_valid", outValid, 0);
    checkOutput("table hit_count", hitCount, 4);
    checkOutput("table out_sticky", outSticky, 1);

    // Clear pulse, then a sticky-mode zero frame reads 0.
    @(negedge clock); clear = 1'b1; #1;
    @(negedge clock); clear = 1'b0; #1;
    checkOutput("clear sticky", outSticky, 0);
    checkOutput("clear hit_count", hitCount, 0);
    @(negedge clock); applyStimulus(1'b1, 8'h00, 1'b1);
    @(negedge clock); applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clock); #1;
    checkOutput("post-clear out_valid", outValid, 1);
    checkOutput("post-clear out_or", outOr, 0);

    // Clear in the same cycle as a hit transfer drops that frame.
    @(negedge clock); applyStimulus(1'b1, 8'hFF, 1'b1);
    @(negedge clock); applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clock); clear = 1'b1; #1;
    checkOutput("clear-hit out_or", outOr, 1);
    @(negedge clock); clear = 1'b0; #1;
    checkOutput("clear-hit hit_count", hitCount, 0);
    checkOutput("clear-hit sticky", outSticky, 0);

    // Backpressure: A and B both accepted, A held, then each exactly once.
    doReset();
    outReady = 1'b0;
    @(negedge clock); applyStimulus(1'b1, 8'h01, 1'b0); #1;
    checkOutput("stall A in_ready", inReady, 1);
    @(negedge clock); applyStimulus(1'b1, 8'h00, 1'b0); #1;
    checkOutput("stall B in_ready", inReady, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); applyStimulus(1'b0, 8'h00, 1'b0); #1;
      checkOutput($sformatf("stall hold%0d out_valid", i), outValid, 1);
      checkOutput($sformatf("stall hold%0d out_or", i), outOr, 1);
      checkOutput($sformatf("stall hold%0d in_ready", i), inReady, 0);
    end
    @(negedge clock); outReady = 1'b1; #1;
    checkOutput("release A valid", outValid, 1);
    checkOutput("release A or", outOr, 1);
    @(negedge clock); #1;
    checkOutput("release B valid", outValid, 1);
    checkOutput("release B or", outOr, 0);
    @(negedge clock); #1;
    checkOutput("release drained", outValid, 0);
    checkOutput("release hit_count", hitCount, 1);

    // COUNT_W=2 saturation and the WIDTH=1 / WIDTH=13 builds.
    doReset();
    begin
      logic        p1[5];
      logic [12:0] p13[5];
      p1  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      p13 = '{13'h1000, 13'h0000, 13'h0040, 13'h0000, 13'h1FFF};
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        if (i < 5) begin
          applyStimulus(1'b1, 8'hFF, 1'b0);
          inData1  = p1[i];
          inData13 = p13[i];
        end else begin
          applyStimulus(1'b0, 8'h00, 1'b0);
        end
        #1;
        if (i >= 3)
          checkOutput($sformatf("cnt2 after %0d", i - 2), hitCountC, (i - 2 > 3) ? 3 : i - 2);
        if (i == 0) checkOutput("w1 latency", outValid1, 0);
        if (i >= 1 && i <= 5) begin
          checkOutput($sformatf("w1 f%0d valid", i - 1), outValid1, 1);
          checkOutput($sformatf("w1 f%0d or", i - 1), outOr1, p1[i-1]);
        end
        if (i == 1) checkOutput("w13 latency", outValid13, 0);
        if (i >= 2 && i <= 6) begin
          checkOutput($sformatf("w13 f%0d valid", i - 2), outValid13, 1);
          checkOutput($sformatf("w13 f%0d or", i - 2), outOr13, p13[i-2] != 13'h0);
        end
      end
    end

    // Reset with frames in flight and the sticky flag set.
    doReset();
    @(negedge clock); applyStimulus(1'b1, 8'hFF, 1'b1);
    @(negedge clock); applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clock);
    @(negedge clock); #1;
    checkOutput("pre-reset sticky", outSticky, 1);
    outReady = 1'b0;
    @(negedge clock); applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge clock); applyStimulus(1'b1, 8'hFF, 1'b0);
    @(negedge clock); applyStimulus(1'b0, 8'h00, 1'b0); reset = 1'b1; #1;
    checkOutput("pre-reset out_valid", outValid, 1);
    @(negedge clock); reset = 1'b0; #1;
    checkOutput("mid reset out_valid", outValid, 0);
    checkOutput("mid reset out_or", outOr, 0);
    checkOutput("mid reset out_sticky", outSticky, 0);
    checkOutput("mid reset hit_count", hitCount, 0);
    checkOutput("mid reset in_ready", inReady, 1);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("flushed c%0d out_valid", i), outValid, 0);
    end

    // Randomized run against the reference model.
    doReset();
    mValid  = '{1'b0, 1'b0};
    mData   = '{8'h00, 8'h00};
    mMode   = '{1'b0, 1'b0};
    mSticky = 1'b0;
    mCount  = 0;
    for (int c = 0; c < 400; c++) begin
      logic expInReady, frameOr, xfer;
      @(negedge clock);
      outReady = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 19) == 0);
      applyStimulus($urandom_range(0, 9) < 7,
                    ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
      #1;
      expInReady = !mValid[1] || outReady;
      frameOr    = (mData[1] != 8'h00);
      checkOutput($sformatf("rnd%0d in_ready", c), inReady, expInReady);
      checkOutput($sformatf("rnd%0d out_valid", c), outValid, mValid[1]);
      if (mValid[1])
        checkOutput($sformatf("rnd%0d out_or", c), outOr, frameOr || (mMode[1] && mSticky));
      checkOutput($sformatf("rnd%0d out_sticky", c), outSticky, mSticky);
      checkOutput($sformatf("rnd%0d hit_count", c), hitCount, mCount);
      xfer = mValid[1] && outReady;
      if (clear) begin
        mSticky = 1'b0;
        mCount  = 0;
      end else if (xfer) begin
        if (mMode[1]) mSticky = mSticky || frameOr;
        if (frameOr && mCount < 255) mCount++;
      end
      if (expInReady) begin
        mValid[1] = mValid[0]; mData[1] = mData[0]; mMode[1] = mMode[0];
        mValid[0] = inValid;   mData[0] = inData;   mMode[0] = inMode;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
